// File: rtl/uart_cmd_bridge.sv
`timescale 1ns/1ps
// Purpose: UART bridge that assembles two received bytes into a 16-bit host command and serialises one response byte.
// Latency: cmd_rdy rises one clk after the second byte's stop-bit sample; resp_sent pulses 10*BAUD_DIV+1 clks after send_resp.
// Backpressure: bytes that complete while cmd_rdy is high are dropped; send_resp is ignored while a byte is in flight.
//
// Ports:
//   clk, rst_n            - system clock, async active-low reset
//   RX / TX               - host serial lines (idle high, 8N1)
//   cmd, cmd_rdy          - assembled command {first byte, second byte} and its level valid
//   clr_cmd_rdy           - core acknowledge, drops cmd_rdy
//   resp, send_resp       - response byte and its start pulse
//   resp_sent             - one-cycle pulse once the stop bit has been fully driven
// Optional feature: define CMD_TMO_EN to discard a lone first byte after TMO_CYC idle cycles.
module uart_cmd_bridge #(
    parameter int BAUD_DIV = 868,
    parameter int TMO_CYC  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);
    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_TXMIT} tx_state_t;

    // ---------------- receive side ----------------
    rx_state_t       rx_state;
    logic            rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic            byte_cnt;
    logic            rx_fall;
    logic            tmo_hit;

    // rx_prev only returns high after the line does, so a framing error
    // naturally waits for an idle-high line before the next start edge.
    assign rx_fall = rx_prev & ~rx_s2;

`ifdef CMD_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts idle cycles spent holding a lone first byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (rx_state == RX_IDLE && byte_cnt && !rx_fall && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
    assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
    if (TMO_CYC < 1) begin : g_tmo_cfg_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            byte_cnt <= 1'b0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CW'(1);
                    end else if (tmo_hit) begin
                        byte_cnt <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;           // glitch, not a start bit
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= CW'(1);
                            rx_bit   <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL) begin
                        rx_cnt   <= CW'(1);
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL) begin
                        rx_state <= RX_IDLE;
                        // Bad stop bit or pending command: byte is dropped, count untouched.
                        if (rx_s2 && !cmd_rdy) begin
                            if (!byte_cnt) begin
                                cmd[15:8] <= rx_shift;
                                byte_cnt  <= 1'b1;
                            end else begin
                                cmd[7:0]  <= rx_shift;
                                cmd_rdy   <= 1'b1;
                                byte_cnt  <= 1'b0;
                            end
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- transmit side ----------------
    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;
    logic [8:0]      tx_shift;   // remaining bits after the start bit: {stop, data}

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '1;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    // A request coinciding with resp_sent is not taken.
                    if (send_resp && !resp_sent) begin
                        tx_state <= TX_TXMIT;
                        tx_shift <= {1'b1, resp};
                        TX       <= 1'b0;
                        tx_cnt   <= CW'(1);
                        tx_bit   <= '0;
                    end
                end
                TX_TXMIT: begin
                    if (tx_cnt == FULL) begin
                        tx_cnt <= CW'(1);
                        if (tx_bit == 4'd9) begin
                            tx_state  <= TX_IDLE;
                            resp_sent <= 1'b1;
                            TX        <= 1'b1;
                        end else begin
                            TX       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for uart_cmd_bridge at BAUD_DIV=16, TMO_CYC=500.
// Latency: checks resp_sent timing and cmd_rdy rise around the second stop bit.
// Backpressure: covers dropped bytes while cmd_rdy is high and ignored send_resp mid-frame.
module tb_uart_cmd_bridge;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send = 1'b0;
    logic        resp_sent;

    int n_chk  = 0;
    int n_pass = 0;

    logic samp_tx [200];
    logic samp_rs [200];

    always #5 clk = ~clk;

    uart_cmd_bridge #(.BAUD_DIV(BD), .TMO_CYC(500)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (rx),
        .TX          (tx),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr),
        .resp        (resp),
        .send_resp   (send),
        .resp_sent   (resp_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drives one 8N1 frame on rx starting at a falling clock edge.
    task automatic uart_send(input logic [7:0] b, input logic stop_bit, input logic chk_pre);
        @(negedge clk);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = stop_bit;
        repeat (4) @(negedge clk);
        if (chk_pre) check("rdy_before_stop_sample", 32'(cmd_rdy), 32'd0);
        repeat (BD - 4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends r and records TX/resp_sent for 200 cycles; optionally a second
    // request (dup_val) is issued at cycle dup_at while the first is in flight.
    task automatic tx_capture(input logic [7:0] r, input int dup_at, input logic [7:0] dup_val,
                              input string tag);
        logic [9:0] frame;
        int pulses, first;
        frame = {1'b1, r, 1'b0};
        @(negedge clk);
        resp = r;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        samp_tx[0] = tx;
        samp_rs[0] = resp_sent;
        for (int c = 1; c < 200; c++) begin
            if (c == dup_at) begin
                resp = dup_val;
                send = 1'b1;
            end
            @(posedge clk);
            #1;
            send = 1'b0;
            samp_tx[c] = tx;
            samp_rs[c] = resp_sent;
        end
        for (int k = 0; k < 10; k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(samp_tx[16*k+8]), 32'(frame[k]));
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 200; c++) begin
            if (samp_rs[c]) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check({tag, "_sent_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_sent_time"}, 32'(first), 32'd160);
        check({tag, "_tx_idle_after"}, 32'(samp_tx[199]), 32'd1);
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int rs_seen;
        logic tx_low_seen;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_resp_sent", 32'(resp_sent), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // two-byte command
        uart_send(8'hA5, 1'b1, 1'b0);
        check("first_byte_no_rdy", 32'(cmd_rdy), 32'd0);
        uart_send(8'h3C, 1'b1, 1'b1);
        check("cmd_rdy_set", 32'(cmd_rdy), 32'd1);
        check("cmd_A53C", 32'(cmd), 32'hA53C);
        repeat (50) @(negedge clk);
        check("cmd_rdy_held", 32'(cmd_rdy), 32'd1);

        // byte arriving while cmd_rdy is high is dropped
        uart_send(8'h77, 1'b1, 1'b0);
        check("drop_keeps_cmd", 32'(cmd), 32'hA53C);
        check("drop_keeps_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();
        check("clr_drops_rdy", 32'(cmd_rdy), 32'd0);
        clear_cmd();
        check("clr_idle_no_effect", 32'(cmd_rdy), 32'd0);

        // 4-cycle glitch on RX
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_rdy", 32'(cmd_rdy), 32'd0);

        // framing error discards 8'h12
        uart_send(8'h12, 1'b0, 1'b0);
        uart_send(8'h34, 1'b1, 1'b0);
        check("frame_err_no_rdy_yet", 32'(cmd_rdy), 32'd0);
        uart_send(8'h56, 1'b1, 1'b0);
        check("cmd_3456", 32'(cmd), 32'h3456);
        check("cmd_3456_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // response transmit with simultaneous receive traffic
        fork
            tx_capture(8'hC3, -1, 8'h00, "txC3");
            begin
                uart_send(8'h11, 1'b1, 1'b0);
                uart_send(8'h22, 1'b1, 1'b0);
            end
        join
        check("duplex_cmd", 32'(cmd), 32'h1122);
        check("duplex_rdy", 32'(cmd_rdy), 32'd1);
        clear_cmd();

        // second send_resp mid-flight is ignored
        tx_capture(8'hC3, 50, 8'h00, "txdup");

        // lone first byte followed by a long gap
        uart_send(8'hFF, 1'b1, 1'b0);
        repeat (600) @(negedge clk);
        uart_send(8'h01, 1'b1, 1'b0);
`ifdef CMD_TMO_EN
        check("tmo_no_rdy_after_01", 32'(cmd_rdy), 32'd0);
        uart_send(8'h02, 1'b1, 1'b0);
        check("tmo_cmd_0102", 32'(cmd), 32'h0102);
        check("tmo_rdy", 32'(cmd_rdy), 32'd1);
`else
        check("notmo_rdy_after_01", 32'(cmd_rdy), 32'd1);
        uart_send(8'h02, 1'b1, 1'b0);
        check("notmo_cmd_FF01", 32'(cmd), 32'hFF01);
`endif

        // reset in the middle of a transmission
        @(negedge clk);
        resp = 8'h5A;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (40) @(negedge clk);
        tx_low_seen = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midtx_rst_tx_high", 32'(tx), 32'd1);
        check("midtx_rst_cmd", 32'(cmd), 32'h0000);
        check("midtx_rst_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rs_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (resp_sent) rs_seen++;
            if (!tx) tx_low_seen = 1'b1;
        end
        check("midtx_rst_no_sent", 32'(rs_seen), 32'd0);
        check("midtx_rst_tx_idle", 32'(tx_low_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868: clk cycles per UART bit (100MHz/115200).
REQ-002 SHALL have parameter TMO_CYC, default 1000000: inter-byte timeout in clk cycles (used only with CMD_TMO_EN).
REQ-003 SHALL have port clk  in  1  100MHz system clock; one clock only.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port RX  in  1  serial line from host, asynchronous, idle high.
REQ-006 SHALL have port TX  out  1  serial line to host, idle high.
REQ-007 SHALL have port cmd  out  16  assembled host command: first byte in [15:8], second byte in [7:0].
REQ-008 SHALL have port cmd_rdy  out  1  level, cmd valid.
REQ-009 SHALL have port clr_cmd_rdy  in  1  pulse from core, knocks down cmd_rdy.
REQ-010 SHALL have port resp  in  8  response byte from core.
REQ-011 SHALL have port send_resp  in  1  pulse, start transmission of resp.
REQ-012 SHALL have port resp_sent  out  1  one-cycle pulse, response fully transmitted.

Function
REQ-013 SHALL synchronize RX through two flops, both preset to 1, before any use.
REQ-014 SHALL run the RX FSM with states IDLE, START, DATA, STOP; IDLE->START on a synchronized falling edge of RX.
REQ-015 SHALL sample the start bit BAUD_DIV/2 cycles after the edge, and return to IDLE if it reads 1 (glitch reject).
REQ-016 SHALL sample 8 data bits, LSB first, every BAUD_DIV cycles after the start-bit sample, then sample the stop bit.
REQ-017 SHALL discard the byte on a stop bit of 0 (framing error) without altering the byte count, then wait in IDLE for RX high before re-arming.
REQ-018 SHALL load a good first byte into cmd[15:8] and a good second byte into cmd[7:0].
REQ-019 SHALL set cmd_rdy on the clk following the second byte's stop-bit sample, then reset the byte count to 0.
REQ-020 SHALL hold cmd_rdy high and cmd stable until clr_cmd_rdy is sampled high; cmd_rdy SHALL be 0 on the next cycle.
REQ-021 SHALL drop any byte completing while cmd_rdy=1; the byte count stays 0.
REQ-022 SHALL cause clr_cmd_rdy while cmd_rdy=0 no effect.
REQ-023 SHALL run the TX FSM with states IDLE, TXMIT; in IDLE, send_resp latches resp into a 10-bit shift register {1,resp,0}.
REQ-024 SHALL drive the start bit on TX from the cycle after send_resp, each bit for exactly BAUD_DIV cycles, LSB first, then the stop bit.
REQ-025 SHALL pulse resp_sent for exactly 1 cycle on the cycle after the stop bit's final cycle, and return to IDLE in that same cycle.
REQ-026 SHALL ignore send_resp while in TXMIT; the in-flight byte is unaffected.
REQ-027 SHALL allow send_resp in the same cycle as resp_sent to be ignored; a new transmission requires send_resp while in IDLE.
REQ-028 SHALL operate RX and TX independently, so full-duplex traffic is legal.
REQ-029 SHALL size baud counters to $clog2(BAUD_DIV)+1 bits, with no wrap within a bit period.

Reset
REQ-030 SHALL, on rst_n low, immediately set TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, both FSMs to IDLE, byte count=0, and sync flops=1.
REQ-031 SHALL make reset mid-frame abort both directions; no partial byte is retained and no resp_sent is issued.

Configuration
REQ-032 SHALL, with macro CMD_TMO_EN defined, clear the byte count to 0 when a first byte has been received and no second-byte start edge arrives within TMO_CYC cycles; the stale high byte is never presented.
REQ-033 SHALL, with CMD_TMO_EN undefined, wait indefinitely for the second byte and synthesize no timeout counter.

Verification
REQ-034 SHALL cover: BAUD_DIV=16, RX frames 8'hA5 then 8'h3C -> cmd=16'hA53C, cmd_rdy=1 one cycle after the second stop sample, held until clr_cmd_rdy, then 0.
REQ-035 SHALL cover: send_resp with resp=8'hC3 -> TX carries 0,1,1,0,0,0,0,1,1,1 at 16 cycles per bit; resp_sent pulses once, 161 cycles after send_resp.
REQ-036 SHALL cover: second send_resp (resp=8'h00) mid-transmission -> TX waveform for 8'hC3 unchanged, a single resp_sent.
REQ-037 SHALL cover: byte 8'h12 with stop bit 0, then 8'h34, 8'h56 -> cmd=16'h3456 (8'h12 discarded).
REQ-038 SHALL cover: a 4-cycle low glitch on RX -> no byte received, cmd_rdy stays 0.
REQ-039 SHALL cover, with CMD_TMO_EN and TMO_CYC=500: 8'hFF, 600-cycle gap, then 8'h01, 8'h02 -> cmd=16'h0102; also rst_n pulsed mid-TX -> TX=1 immediately and no resp_sent.
